dma_priority_arbiter: RTL and testbench
=======================================

// Module: dma_priority_arbiter
// PURPOSE
//  Parametrised DREQ/DACK arbiter for the DMA controller: N channels, per-channel masks, fixed or rotating priority.
//  Sits between the DREQ pins and the transfer FSM: runs the HRQ/HLDA bus handshake with the CPU.
//  Drives DACK for the winning channel and holds the grant until the transfer FSM reports service done.
//  Exports per-channel priority rank and sticky TC status for register readback.
// PARAMETERS
//  NUM_CH  4                 channel count; power of two, 2..16
//  CH_W    $clog2(NUM_CH)    channel index width; derived, do not override
// PORTS
//  CLK            in   1               clock; all state updates on rising edge
//  RESET          in   1               asynchronous, active-low reset
//  dreq           in   NUM_CH          DMA requests, already synchronised to CLK
//  dreqActiveHigh in   1               DREQ polarity; 1 = active high
//  dackActiveHigh in   1               DACK polarity; 1 = active high
//  ctrlEnable     in   1               controller enable; 0 blocks new arbitration
//  rotatePriority in   1               0 = fixed priority (ch0 highest), 1 = rotating
//  maskAllWr      in   1               write whole mask register from maskData
//  maskData       in   NUM_CH          mask value for maskAllWr
//  maskOneWr      in   1               write a single mask bit
//  maskOneCh      in   CH_W            channel for maskOneWr
//  maskOneVal     in   1               bit value for maskOneWr
//  hlda           in   1               hold acknowledge from CPU
//  svcDone        in   1               1-cycle pulse from transfer FSM: service of the granted channel ended
//  svcTc          in   1               qualifies svcDone: service ended on terminal count
//  statusRd       in   1               1-cycle pulse: status read; clears tcStatus
//  hrq            out  1               hold request to CPU
//  dack           out  NUM_CH          DMA acknowledges, polarity per dackActiveHigh
//  grantValid     out  1               1 while in GRANT
//  grantCh        out  CH_W            granted channel; holds last value outside GRANT
//  maskReg        out  NUM_CH          current mask register
//  tcStatus       out  NUM_CH          sticky TC-reached bits
//  chPriority     out  NUM_CH*CH_W     rank per channel; 0 = highest; field i = bits [i*CH_W +: CH_W]
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE, hrq=0, grantValid=0, grantCh=0, maskReg=all 1s, tcStatus=0, ptr=0.
//   dack is driven to its inactive level {NUM_CH{~dackActiveHigh}} during and after reset.
//  Valid request: validReq[i] = (dreq[i] ~^ dreqActiveHigh) & ~maskReg[i] & ctrlEnable.
//  Priority:
//   ptr = channel with highest priority; rank[i] = (i - ptr) mod NUM_CH, CH_W-bit wrap.
//   rotatePriority=0 forces ptr=0 every cycle.
//   rotatePriority=1: on svcDone in GRANT, ptr <= (grantCh + 1) mod NUM_CH.
//   Winner = validReq channel with lowest rank; evaluated only on the REQ->GRANT transition.
//  FSM (registered outputs):
//   IDLE:    |validReq -> REQ (hrq=1 the following cycle).
//   REQ:     hrq=1; hlda=1 & |validReq -> GRANT with winner latched into grantCh.
//            hlda=1 & no validReq (withdrawn) -> RELEASE.
//            hlda=0 -> stay in REQ, even if requests vanish; hrq is never dropped before hlda.
//   GRANT:   hrq=1, grantValid=1, dack[grantCh] active, all other dack bits inactive.
//            svcDone -> RELEASE.
//            hlda=0 (preempted) -> RELEASE with no ptr update; a simultaneous svcDone still counts.
//   RELEASE: hrq=0, dack all inactive for exactly 1 cycle -> IDLE.
//  Latency: hlda high in REQ -> dack active the next cycle. svcDone -> dack inactive the next cycle.
//  Masks:
//   maskAllWr and maskOneWr in the same cycle: maskAllWr applied first, then maskOneWr overrides its bit.
//   Masking or ctrlEnable=0 during GRANT does not abort the grant; the effect applies at the next arbitration.
//  tcStatus[grantCh] set on svcDone&svcTc. If statusRd coincides, the clear applies first and the new set still lands.
//  Polarity or rotatePriority changes mid-operation take effect at the next arbitration.
//   dack levels follow dackActiveHigh combinationally.
//  svcDone outside GRANT is ignored.
// CONFIGURATION
//  DMA_ARB_AUTOMASK_EN defined:
//   svcDone&svcTc in GRANT also sets maskReg[grantCh]=1.
//   A same-cycle mask write to that bit is overridden by the auto-mask.
//  Not defined: maskReg changes only via maskAllWr/maskOneWr.
// TESTING
//  1 Reset: RESET=0 with dackActiveHigh=0 -> dack=4'b1111, hrq=0, maskReg=4'b1111, tcStatus=0, chPriority={2'd3,2'd2,2'd1,2'd0}.
//  2 Fixed priority: maskAllWr 4'b0000, dreq ch1+ch3, hlda 2 cycles later -> dack[1] active, grantCh=1;
//    svcDone -> 1 cycle hrq=0, then re-request grants ch1 again.
//  3 Rotating: all 4 dreq held, svcDone each grant -> grants 0,1,2,3,0.
//    After ch1 served, ranks ch2=0, ch3=1, ch0=2, ch1=3.
//  4 Preempt: hlda dropped mid-GRANT on ch2 -> dack inactive next cycle, RELEASE, ptr unchanged.
//  5 Withdraw: dreq0 pulse, released before hlda -> REQ holds hrq=1; hlda=1 -> RELEASE, dack never active.
//  6 TC: svcDone&svcTc on ch2 -> tcStatus=4'b0100; statusRd -> 0.
//    With DMA_ARB_AUTOMASK_EN maskReg[2]=1; without it maskReg unchanged.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// DREQ/DACK arbiter bus bundle: request pins, CPU hold handshake, transfer-FSM
// service strobes, mask/status register access and readback.
// master = arbiter side, slave = surrounding controller / pins.
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]      dreq;
  logic                   dreqActiveHigh;
  logic                   dackActiveHigh;
  logic                   ctrlEnable;
  logic                   rotatePriority;
  logic                   maskAllWr;
  logic [NUM_CH-1:0]      maskData;
  logic                   maskOneWr;
  logic [CH_W-1:0]        maskOneCh;
  logic                   maskOneVal;
  logic                   hlda;
  logic                   svcDone;
  logic                   svcTc;
  logic                   statusRd;
  logic                   hrq;
  logic [NUM_CH-1:0]      dack;
  logic                   grantValid;
  logic [CH_W-1:0]        grantCh;
  logic [NUM_CH-1:0]      maskReg;
  logic [NUM_CH-1:0]      tcStatus;
  logic [NUM_CH*CH_W-1:0] chPriority;

  modport master (
    input  dreq, dreqActiveHigh, dackActiveHigh, ctrlEnable, rotatePriority,
           maskAllWr, maskData, maskOneWr, maskOneCh, maskOneVal,
           hlda, svcDone, svcTc, statusRd,
    output hrq, dack, grantValid, grantCh, maskReg, tcStatus, chPriority
  );

  modport slave (
    output dreq, dreqActiveHigh, dackActiveHigh, ctrlEnable, rotatePriority,
           maskAllWr, maskData, maskOneWr, maskOneCh, maskOneVal,
           hlda, svcDone, svcTc, statusRd,
    input  hrq, dack, grantValid, grantCh, maskReg, tcStatus, chPriority
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA DREQ/DACK priority arbiter: N channels, per-channel masks, fixed or
// rotating priority, HRQ/HLDA hold handshake, sticky TC status.
// Optional feature macro: DMA_ARB_AUTOMASK_EN -- a terminal-count service
// completion also masks the served channel.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dma_priority_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     grantCh_q, grantCh_d;
  logic [NUM_CH-1:0]   maskReg_q, maskReg_d;
  logic [NUM_CH-1:0]   tcStatus_q, tcStatus_d;

  logic [NUM_CH-1:0]   validReq;
  logic                anyValid;
  logic [CH_W-1:0]     winner;
  logic                winnerFound;
  logic [CH_W-1:0]     scanIdx;
  logic                svcEvent;
  logic                tcEvent;
  logic [NUM_CH-1:0]   dackAct;
  logic [NUM_CH*CH_W-1:0] rankVec;

  // Qualify raw requests with polarity, mask and global enable
  always_comb begin
    validReq = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      validReq[i] = (bus.dreq[i] ~^ bus.dreqActiveHigh) & ~maskReg_q[i] & bus.ctrlEnable;
    end
  end

  assign anyValid = |validReq;

  // Scan channels starting at ptr; the first valid one has the lowest rank
  always_comb begin
    winner      = ptr_q;
    winnerFound = 1'b0;
    scanIdx     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scanIdx = ptr_q + CH_W'(k);
      if (!winnerFound && validReq[scanIdx]) begin
        winner      = scanIdx;
        winnerFound = 1'b1;
      end
    end
  end

  // Service completion only counts while a grant is held
  assign svcEvent = (state_q == S_GRANT) & bus.svcDone;
  assign tcEvent  = svcEvent & bus.svcTc;

  // Next-state logic for the hold/grant handshake
  always_comb begin
    state_d   = state_q;
    grantCh_d = grantCh_q;
    unique case (state_q)
      S_IDLE: begin
        if (anyValid) state_d = S_REQ;
      end
      S_REQ: begin
        // hrq stays up until hlda arrives, even if requests are withdrawn
        if (bus.hlda) begin
          if (anyValid) begin
            state_d   = S_GRANT;
            grantCh_d = winner;
          end else begin
            state_d   = S_RELEASE;
          end
        end
      end
      S_GRANT: begin
        if (bus.svcDone || !bus.hlda) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Rotation pointer: pinned to 0 in fixed mode, advances past the served channel
  always_comb begin
    ptr_d = ptr_q;
    if (!bus.rotatePriority) begin
      ptr_d = '0;
    end else if (svcEvent) begin
      ptr_d = grantCh_q + CH_W'(1);
    end
  end

  // Mask register: whole-register write first, single-bit write overrides
  always_comb begin
    maskReg_d = maskReg_q;
    if (bus.maskAllWr) maskReg_d = bus.maskData;
    if (bus.maskOneWr) maskReg_d[bus.maskOneCh] = bus.maskOneVal;
`ifdef DMA_ARB_AUTOMASK_EN
    if (tcEvent) maskReg_d[grantCh_q] = 1'b1;
`endif
  end

  // Sticky TC bits: a status read clears first, a coincident TC still sets
  always_comb begin
    tcStatus_d = tcStatus_q;
    if (bus.statusRd) tcStatus_d = '0;
    if (tcEvent) tcStatus_d[grantCh_q] = 1'b1;
  end

  // State and register update
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grantCh_q  <= '0;
      maskReg_q  <= '1;
      tcStatus_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grantCh_q  <= grantCh_d;
      maskReg_q  <= maskReg_d;
      tcStatus_q <= tcStatus_d;
    end
  end

  // Acknowledge decode for the granted channel, plus per-channel rank readback
  always_comb begin
    dackAct = '0;
    rankVec = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      dackAct[i] = (state_q == S_GRANT) && (grantCh_q == CH_W'(i));
      rankVec[i*CH_W +: CH_W] = CH_W'(i) - ptr_q;
    end
  end

  assign bus.hrq        = (state_q == S_REQ) || (state_q == S_GRANT);
  assign bus.grantValid = (state_q == S_GRANT);
  assign bus.grantCh    = grantCh_q;
  assign bus.dack       = bus.dackActiveHigh ? dackAct : ~dackAct;
  assign bus.maskReg    = maskReg_q;
  assign bus.tcStatus   = tcStatus_q;
  assign bus.chPriority = rankVec;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter (NUM_CH=4): reset values,
// a table of fixed-priority cycles, hand sequences for rotation, preemption,
// withdrawal and TC status, then randomized traffic against a reference model.
module tb_dma_priority_arbiter;
  localparam int N  = 4;
  localparam int CW = 2;

  logic clk;
  logic rst_n;

  dma_priority_arbiter_if #(.NUM_CH(N)) bus ();

  dma_priority_arbiter #(.NUM_CH(N)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: bus ownership phase, granted channel, top-priority channel
  bit        m_asking, m_granted, m_releasing;
  int        m_ch, m_ptr;
  bit [N-1:0] m_mask, m_tc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_asking = 0; m_granted = 0; m_releasing = 0;
    m_ch = 0; m_ptr = 0; m_mask = '1; m_tc = '0;
  endtask

  task automatic model_step();
    bit [N-1:0] v;
    bit [N-1:0] nm, nt;
    int best, bestRank, r, np, nch;
    bit na, ng, nr, done;
    done = m_granted && bus.svcDone;
    for (int i = 0; i < N; i++)
      v[i] = (bus.dreq[i] == bus.dreqActiveHigh) && !m_mask[i] && bus.ctrlEnable;
    best = -1; bestRank = N;
    for (int i = 0; i < N; i++) begin
      r = (i - m_ptr + N) % N;
      if (v[i] && r < bestRank) begin bestRank = r; best = i; end
    end
    np = !bus.rotatePriority ? 0 : (done ? (m_ch + 1) % N : m_ptr);
    nt = bus.statusRd ? '0 : m_tc;
    if (done && bus.svcTc) nt[m_ch] = 1'b1;
    nm = bus.maskAllWr ? bus.maskData : m_mask;
    if (bus.maskOneWr) nm[bus.maskOneCh] = bus.maskOneVal;
`ifdef DMA_ARB_AUTOMASK_EN
    if (done && bus.svcTc) nm[m_ch] = 1'b1;
`endif
    na = 0; ng = 0; nr = 0; nch = m_ch;
    if (m_releasing) begin
      // back to idle
    end else if (m_granted) begin
      if (bus.svcDone || !bus.hlda) nr = 1; else ng = 1;
    end else if (m_asking) begin
      if (!bus.hlda) na = 1;
      else if (best >= 0) begin ng = 1; nch = best; end
      else nr = 1;
    end else begin
      if (best >= 0) na = 1;
    end
    m_asking = na; m_granted = ng; m_releasing = nr;
    m_ch = nch; m_ptr = np; m_mask = nm; m_tc = nt;
  endtask

  task automatic model_compare();
    logic [N-1:0]    ed;
    logic [N*CW-1:0] ep;
    for (int i = 0; i < N; i++) begin
      ed[i] = (m_granted && m_ch == i) ? bus.dackActiveHigh : ~bus.dackActiveHigh;
      ep[i*CW +: CW] = CW'((i - m_ptr + N) % N);
    end
    chk("model",
        {bus.hrq, bus.grantValid, bus.grantCh, bus.dack, bus.maskReg, bus.tcStatus, bus.chPriority},
        {(m_asking || m_granted), m_granted, CW'(m_ch), ed, m_mask, m_tc, ep});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_compare();
  endtask

  task automatic set_mask(input logic [N-1:0] v);
    bus.maskAllWr = 1'b1; bus.maskData = v;
    tick();
    bus.maskAllWr = 1'b0;
  endtask

  task automatic wait_grant(input int exp_ch, input string nm);
    int n = 0;
    while (!bus.grantValid && n < 10) begin tick(); n++; end
    chk({nm, "_wait"}, bus.grantValid, 1);
    chk({nm, "_ch"}, bus.grantCh, exp_ch);
  endtask

  task automatic serve_one(input int exp_ch);
    wait_grant(exp_ch, $sformatf("rot%0d", exp_ch));
    bus.svcDone = 1'b1;
    tick();
    bus.svcDone = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] dreq;
    logic hlda, svcDone, svcTc, statusRd;
    logic e_hrq;
    logic [N-1:0] e_dack;
    logic e_gv;
    logic [CW-1:0] e_gch;
    logic [N-1:0] e_tc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Fixed-priority grant/release cycle, one row per clock
    vecs[0] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[1] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[2] = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0000};
    vecs[3] = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0000};
    vecs[4] = '{4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000};
    vecs[5] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000};
    vecs[6] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b0000};
    vecs[7] = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0000};
    vecs[8] = '{4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0010};
    vecs[9] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000};

    rst_n = 1'b0;
    bus.dreq = '0; bus.dreqActiveHigh = 1'b1; bus.dackActiveHigh = 1'b0;
    bus.ctrlEnable = 1'b1; bus.rotatePriority = 1'b0;
    bus.maskAllWr = 1'b0; bus.maskData = '0;
    bus.maskOneWr = 1'b0; bus.maskOneCh = '0; bus.maskOneVal = 1'b0;
    bus.hlda = 1'b0; bus.svcDone = 1'b0; bus.svcTc = 1'b0; bus.statusRd = 1'b0;
    model_reset();

    // Reset values
    #12;
    chk("rst_dack", bus.dack, 4'b1111);
    chk("rst_hrq", bus.hrq, 0);
    chk("rst_gv", bus.grantValid, 0);
    chk("rst_gch", bus.grantCh, 0);
    chk("rst_mask", bus.maskReg, 4'b1111);
    chk("rst_tc", bus.tcStatus, 0);
    chk("rst_prio", bus.chPriority, 8'b11_10_01_00);
    #10;
    rst_n = 1'b1;
    bus.dackActiveHigh = 1'b1;

    // Fixed priority table
    set_mask(4'b0000);
    for (int r = 0; r < 10; r++) begin
      bus.dreq = vecs[r].dreq; bus.hlda = vecs[r].hlda; bus.svcDone = vecs[r].svcDone;
      bus.svcTc = vecs[r].svcTc; bus.statusRd = vecs[r].statusRd;
      tick();
      chk($sformatf("vec%0d_hrq", r), bus.hrq, vecs[r].e_hrq);
      chk($sformatf("vec%0d_dack", r), bus.dack, vecs[r].e_dack);
      chk($sformatf("vec%0d_gv", r), bus.grantValid, vecs[r].e_gv);
      chk($sformatf("vec%0d_gch", r), bus.grantCh, vecs[r].e_gch);
      chk($sformatf("vec%0d_tc", r), bus.tcStatus, vecs[r].e_tc);
    end
    bus.svcDone = 1'b0; bus.svcTc = 1'b0; bus.statusRd = 1'b0;
    tick();

    // Rotating priority: grants 0,1,2,3,0
    bus.rotatePriority = 1'b1;
    set_mask(4'b0000);
    bus.dreq = 4'b1111; bus.hlda = 1'b1;
    serve_one(0);
    serve_one(1);
    chk("rot_ranks", bus.chPriority, 8'b01_00_11_10);
    serve_one(2);
    serve_one(3);
    serve_one(0);
    bus.dreq = '0; bus.hlda = 1'b0;
    tick(); tick();

    // Preemption on ch2: hlda drop releases, pointer stays at 1
    set_mask(4'b1011);
    bus.dreq = 4'b1111; bus.hlda = 1'b1;
    wait_grant(2, "pre");
    chk("pre_dack_on", bus.dack, 4'b0100);
    bus.hlda = 1'b0;
    tick();
    chk("pre_dack_off", bus.dack, 4'b0000);
    chk("pre_hrq", bus.hrq, 0);
    chk("pre_prio", bus.chPriority, 8'b10_01_00_11);
    bus.dreq = '0;
    tick(); tick();

    // Withdrawn request: hrq held until hlda, dack never active
    set_mask(4'b0000);
    bus.dreq = 4'b0001;
    tick();
    chk("wd_req", bus.hrq, 1);
    bus.dreq = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("wd_hold%0d", c), {bus.hrq, bus.dack}, {1'b1, 4'b0000});
    end
    bus.hlda = 1'b1;
    tick();
    chk("wd_rel", {bus.hrq, bus.grantValid, bus.dack}, {1'b0, 1'b0, 4'b0000});
    bus.hlda = 1'b0;
    tick();

    // Terminal count on ch2 with coincident status read, then a plain read
    set_mask(4'b0000);
    bus.dreq = 4'b0100; bus.hlda = 1'b1;
    wait_grant(2, "tc");
    bus.dreq = '0; bus.svcDone = 1'b1; bus.svcTc = 1'b1; bus.statusRd = 1'b1;
    tick();
    chk("tc_set", bus.tcStatus, 4'b0100);
`ifdef DMA_ARB_AUTOMASK_EN
    chk("tc_mask", bus.maskReg, 4'b0100);
`else
    chk("tc_mask", bus.maskReg, 4'b0000);
`endif
    bus.svcDone = 1'b0; bus.svcTc = 1'b0;
    tick();
    chk("tc_clear", bus.tcStatus, 4'b0000);
    bus.statusRd = 1'b0; bus.hlda = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.dreq       = N'($urandom);
      bus.hlda       = (m_asking || m_granted) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      bus.svcDone    = ($urandom_range(0, 3) == 0);
      bus.svcTc      = $urandom_range(0, 1) != 0;
      bus.statusRd   = ($urandom_range(0, 7) == 0);
      bus.maskAllWr  = ($urandom_range(0, 15) == 0);
      bus.maskData   = N'($urandom);
      bus.maskOneWr  = ($urandom_range(0, 7) == 0);
      bus.maskOneCh  = CW'($urandom_range(0, N - 1));
      bus.maskOneVal = ($urandom_range(0, 2) == 0);
      bus.ctrlEnable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) bus.rotatePriority = ~bus.rotatePriority;
      if ($urandom_range(0, 63) == 0) bus.dreqActiveHigh = ~bus.dreqActiveHigh;
      if ($urandom_range(0, 63) == 0) bus.dackActiveHigh = ~bus.dackActiveHigh;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
